pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC fetched first after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  high SHALL block issue of new fetch requests.
REQ-005 redirect_valid  input  1  taken jump/branch, driven from next_pc pc_src.
REQ-006 redirect_target  input  32  new PC, driven from next_pc target_address.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address, stable while imem_req=1 and imem_gnt=0.
REQ-009 imem_gnt  input  1  request accepted this cycle.
REQ-010 imem_rvalid  input  1  response data valid; exactly one per grant, at least 1 cycle after gnt.
REQ-011 imem_rdata  input  32  fetched instruction.
REQ-012 if_valid  output  1  held instruction valid to decode.
REQ-013 if_ready  input  1  decode accepts; transfer when if_valid && if_ready.
REQ-014 if_pc  output  32  PC of held instruction; feeds next_pc pc input.
REQ-015 if_instr  output  32  held instruction word.

Function
REQ-016 States S_IDLE, S_REQ, S_WAIT, S_HOLD; imem_req=1 only in S_REQ; if_valid=1 only in S_HOLD.
REQ-017 Registers: fetch_pc (drives imem_addr), kill flag, pending_pc.
REQ-018 S_IDLE: !stall -> S_REQ next cycle; stall -> remain.
REQ-019 S_REQ: imem_gnt -> S_WAIT; else remain, imem_addr unchanged.
REQ-020 S_WAIT, rvalid, kill=0: if_instr<=rdata, if_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), -> S_HOLD.
REQ-021 S_WAIT, rvalid, kill=1: response discarded, fetch_pc<=pending_pc, kill<=0, -> S_IDLE.
REQ-022 S_HOLD: if_ready && !stall -> S_REQ; if_ready && stall -> S_IDLE; !if_ready -> remain, if_* stable.
REQ-023 Redirect target SHALL have bits [1:0] forced to 0 before use.
REQ-024 Redirect in S_IDLE: fetch_pc<=target; state transition per REQ-018 unchanged.
REQ-025 Redirect in S_REQ or S_WAIT: request not withdrawn; kill<=1, pending_pc<=target; last redirect before discard wins.
REQ-026 Redirect in S_WAIT coincident with rvalid: response discarded, fetch_pc<=target, -> S_IDLE.
REQ-027 Redirect in S_HOLD: held instruction dropped (if_valid=0 next cycle) regardless of if_ready, fetch_pc<=target, -> S_IDLE.
REQ-028 Redirect SHALL take priority over sequential increment in every state.
REQ-029 Minimum fetch latency: 3 cycles from S_REQ entry to if_valid with gnt and rvalid each after 1 cycle.

Reset
REQ-030 rst_n low SHALL immediately force S_IDLE, fetch_pc=RESET_PC, kill=0, pending_pc=0, if_pc=0, if_instr=0, imem_req=0, if_valid=0.
REQ-031 Reset mid-transaction: any later imem_rvalid for the aborted request is the memory's responsibility to suppress; no outstanding state survives.

Configuration
REQ-032 Macro PC_SEQ_ALIGN_CHECK_EN defined: output misalign_err (1 bit) SHALL set on redirect with target[1:0]!=0, sticky until reset (reset value 0); redirect still taken with bits cleared.
REQ-033 Macro undefined: misalign_err port absent; low bits silently cleared.

Verification
REQ-034 Reset release, stall=0, gnt/rvalid 1 cycle after, if_ready=1 -> fetch addrs 0x0, 0x4, 0x8; if_pc matches each.
REQ-035 Redirect to 0x100 in S_WAIT, rvalid 2 cycles later -> data dropped, next imem_addr=0x100, no if_valid for old fetch.
REQ-036 S_HOLD with if_ready=0 for 5 cycles -> if_valid, if_pc, if_instr stable; no imem_req.
REQ-037 Redirect 0x200 then 0x300 while kill=1 -> next fetch at 0x300.
REQ-038 fetch_pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-039 With PC_SEQ_ALIGN_CHECK_EN, redirect 0x103 -> imem_addr=0x100, misalign_err=1 until rst_n low.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side bus tying the PC sequencer to instruction memory,
// the branch unit (redirects) and decode.
interface pc_sequencer_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   modport master (
      input  stall, redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );
   modport slave (
      output stall, redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: single-outstanding instruction fetch sequencer with redirect/kill handling.
// Optional PC_SEQ_ALIGN_CHECK_EN adds a sticky misalign_err output for misaligned redirect targets.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst_n,
`ifdef PC_SEQ_ALIGN_CHECK_EN
   output logic           misalign_err,
`endif
   pc_sequencer_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;
   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        kill_q, kill_d;
   logic        redir;
   logic [31:0] target;
   assign redir  = bus.redirect_valid;
   assign target = bus.redirect_target & ~32'd3;
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      kill_d       = kill_q;
      case (state_q)
         S_IDLE: begin
            state_d    = bus.stall ? S_IDLE : S_REQ;
            fetch_pc_d = redir ? target : fetch_pc_q;
         end
         S_REQ: begin
            state_d      = bus.imem_gnt ? S_WAIT : S_REQ;
            kill_d       = kill_q | redir;
            pending_pc_d = redir ? target : pending_pc_q;
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               // A response for a killed or redirected fetch is dropped and fetch restarts from idle
               kill_d  = 1'b0;
               state_d = S_IDLE;
               if (redir) begin
                  fetch_pc_d = target;
               end else if (kill_q) begin
                  fetch_pc_d = pending_pc_q;
               end else begin
                  if_instr_d = bus.imem_rdata;
                  if_pc_d    = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = S_HOLD;
               end
            end else begin
               kill_d       = kill_q | redir;
               pending_pc_d = redir ? target : pending_pc_q;
            end
         end
         default: begin
            if (redir) begin
               fetch_pc_d = target;
               state_d    = S_IDLE;
            end else if (bus.if_ready) begin
               state_d = bus.stall ? S_IDLE : S_REQ;
            end
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= 32'd0;
         if_pc_q      <= 32'd0;
         if_instr_q   <= 32'd0;
         kill_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         kill_q       <= kill_d;
      end
   end
   assign bus.imem_req  = (state_q == S_REQ);
   assign bus.imem_addr = fetch_pc_q;
   assign bus.if_valid  = (state_q == S_HOLD);
   assign bus.if_pc     = if_pc_q;
   assign bus.if_instr  = if_instr_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic misalign_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_q | (redir & (|bus.redirect_target[1:0]));
   end
   assign misalign_err = misalign_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus a randomized run checked against a
// delivered-PC-stream model of the fetch sequencer.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   pc_sequencer_if bus();
`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic misalign_err;
`endif
   pc_sequencer dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef PC_SEQ_ALIGN_CHECK_EN
      .misalign_err(misalign_err),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   int errors = 0;
   int checks = 0;
   bit          mem_busy, rand_mem;
   int          rv_cnt, req_wait, gnt_delay, rv_delay;
   logic [31:0] mem_addr;
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
   endfunction
   task automatic mem_reset();
      mem_busy = 0; rv_cnt = 0; req_wait = 0;
      bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
   endtask
   // Advance one clock; the memory model then sets gnt/rvalid for the new cycle.
   task automatic tick();
      @(posedge clk); #1;
      bus.imem_rvalid = 0;
      if (mem_busy) begin
         if (rv_cnt == 0) begin
            bus.imem_rvalid = 1; bus.imem_rdata = instr_of(mem_addr); mem_busy = 0;
         end else rv_cnt--;
      end
      bus.imem_gnt = 0;
      if (bus.imem_req && !mem_busy) begin
         if (rand_mem ? ($urandom_range(1, 0) == 1) : (req_wait >= gnt_delay)) begin
            bus.imem_gnt = 1; mem_busy = 1; mem_addr = bus.imem_addr; req_wait = 0;
            rv_cnt = rand_mem ? int'($urandom_range(3, 0)) : rv_delay;
         end else req_wait++;
      end
   endtask
   task automatic wait_grant(output logic [31:0] a, output bit ok);
      ok = 0; a = 'x;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if (bus.imem_gnt) begin ok = 1; a = bus.imem_addr; end
      end
   endtask
   task automatic wait_valid(output bit ok);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         ok = bus.if_valid;
      end
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.if_pc); end
      checks++; if (bus.if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.if_instr); end
      checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
      rst_n = 1;
      tick(); tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle: got req=%b expected 0", bus.imem_req); end
   endtask
   task automatic test_sequential();
      logic [31:0] ga [3];
      logic [31:0] dp [3];
      logic [31:0] di [3];
      int cyc = 0, first_req = -1, lat = -1, ng = 0, nd = 0;
      gnt_delay = 1; rv_delay = 0; bus.if_ready = 1; bus.stall = 0;
      for (int i = 0; i < 60 && nd < 3; i++) begin
         tick(); cyc++;
         if (bus.imem_req && first_req < 0) first_req = cyc;
         if (bus.if_valid && lat < 0) lat = cyc - first_req;
         if (bus.imem_gnt && ng < 3) begin ga[ng] = bus.imem_addr; ng++; end
         if (bus.if_valid && bus.if_ready) begin dp[nd] = bus.if_pc; di[nd] = bus.if_instr; nd++; end
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL latency: got %0d expected 3", lat); end
      checks++; if (nd != 3) begin errors++; $display("FAIL seq_count: got %0d expected 3", nd); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (ga[k] !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", k, ga[k], 32'(4 * k)); end
         checks++; if (dp[k] !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", k, dp[k], 32'(4 * k)); end
         checks++; if (di[k] !== instr_of(32'(4 * k))) begin errors++; $display("FAIL seq_instr%0d: got %h expected %h", k, di[k], instr_of(32'(4 * k))); end
      end
   endtask
   task automatic test_hold_stable();
      bit ok;
      logic [31:0] sp, si;
      bus.if_ready = 0; bus.stall = 0;
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: got no if_valid expected if_valid"); end
      sp = bus.if_pc; si = bus.if_instr;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== sp || bus.if_instr !== si || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable%0d: got v=%b pc=%h ins=%h req=%b expected v=1 pc=%h ins=%h req=0",
                     k, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_req, sp, si);
         end
      end
   endtask
   task automatic test_redirect_wait();
      bit ok, seen_old = 0, got = 0;
      logic [31:0] a, g = 'x;
      bus.if_ready = 1; bus.stall = 0; gnt_delay = 0; rv_delay = 2;
      wait_grant(a, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rw_grant_timeout: got no grant expected grant"); end
      tick();
      bus.redirect_valid = 1; bus.redirect_target = 32'h100;
      tick();
      bus.redirect_valid = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (bus.if_valid) seen_old = 1;
         if (bus.imem_gnt) begin got = 1; g = bus.imem_addr; end
      end
      checks++; if (seen_old) begin errors++; $display("FAIL rw_dropped: got if_valid for killed fetch expected none"); end
      checks++; if (g !== 32'h100) begin errors++; $display("FAIL rw_addr: got %h expected 00000100", g); end
      wait_valid(ok);
      checks++;
      if (!ok || bus.if_pc !== 32'h100 || bus.if_instr !== instr_of(32'h100)) begin
         errors++; $display("FAIL rw_deliver: got v=%b pc=%h ins=%h expected pc=00000100 ins=%h", ok, bus.if_pc, bus.if_instr, instr_of(32'h100));
      end
   endtask
   task automatic test_double_redirect();
      bit seen = 0;
      logic [31:0] old = 'x, d0 = 'x;
      logic [31:0] g [2];
      int ng = 0, nd = 0;
      gnt_delay = 3; rv_delay = 0; bus.if_ready = 1; bus.stall = 0;
      for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.imem_req; end
      old = bus.imem_addr;
      bus.redirect_valid = 1; bus.redirect_target = 32'h200; tick();
      bus.redirect_target = 32'h300; tick();
      bus.redirect_valid = 0;
      for (int i = 0; i < 60 && nd < 1; i++) begin
         tick();
         if (bus.imem_gnt && ng < 2) begin g[ng] = bus.imem_addr; ng++; end
         if (bus.if_valid && nd < 1) begin d0 = bus.if_pc; nd++; end
      end
      checks++; if (g[0] !== old) begin errors++; $display("FAIL dr_not_withdrawn: got %h expected %h", g[0], old); end
      checks++; if (g[1] !== 32'h300) begin errors++; $display("FAIL dr_addr: got %h expected 00000300", g[1]); end
      checks++; if (d0 !== 32'h300) begin errors++; $display("FAIL dr_pc: got %h expected 00000300", d0); end
   endtask
   task automatic test_wrap();
      logic [31:0] g [2];
      logic [31:0] d0 = 'x, i0 = 'x;
      int ng = 0, nd = 0;
      bus.stall = 1; bus.if_ready = 1; gnt_delay = 0; rv_delay = 0;
      repeat (8) tick();
      checks++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got req=%b v=%b expected 0 0", bus.imem_req, bus.if_valid); end
      bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFF; tick();
      bus.redirect_valid = 0; bus.stall = 0;
      for (int i = 0; i < 60 && !(ng == 2 && nd == 1); i++) begin
         tick();
         if (bus.imem_gnt && ng < 2) begin g[ng] = bus.imem_addr; ng++; end
         if (bus.if_valid && nd < 1) begin d0 = bus.if_pc; i0 = bus.if_instr; nd++; end
      end
      checks++; if (g[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", g[0]); end
      checks++; if (g[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", g[1]); end
      checks++; if (d0 !== 32'hFFFF_FFFC || i0 !== instr_of(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_deliver: got pc=%h ins=%h expected fffffffc %h", d0, i0, instr_of(32'hFFFF_FFFC)); end
`ifdef PC_SEQ_ALIGN_CHECK_EN
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
`endif
   endtask
   task automatic test_async_reset();
      bit ok;
      logic [31:0] a;
      bus.if_ready = 0; bus.stall = 0;
      wait_valid(ok);
      #2 rst_n = 0;
      #1;
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'd0 || bus.imem_addr !== 32'd0) begin
         errors++; $display("FAIL async_reset: got v=%b req=%b pc=%h ins=%h addr=%h expected all 0",
                            bus.if_valid, bus.imem_req, bus.if_pc, bus.if_instr, bus.imem_addr);
      end
`ifdef PC_SEQ_ALIGN_CHECK_EN
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", misalign_err); end
`endif
      mem_reset();
      tick(); tick();
      rst_n = 1;
      wait_grant(a, ok);
      checks++; if (!ok || a !== 32'd0) begin errors++; $display("FAIL post_reset_addr: got %h expected 00000000", a); end
   endtask
   task automatic test_random();
      logic [31:0] exp_pc = 'x, sp, si, sa;
      bit hold_prev, req_prev;
      int ndel = 0;
      rand_mem = 1;
      for (int i = 0; i < 3000; i++) begin
         bus.stall = ($urandom_range(3, 0) == 0);
         bus.if_ready = ($urandom_range(9, 0) < 6);
         bus.redirect_valid = (i == 0) || ($urandom_range(19, 0) == 0);
         bus.redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
         checks++; if (bus.if_valid && bus.imem_req) begin errors++; $display("FAIL rnd_exclusive: got req=1 v=1 expected not both"); end
         if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
            checks++; ndel++;
            if (bus.if_pc !== exp_pc || bus.if_instr !== instr_of(exp_pc)) begin
               errors++; $display("FAIL rnd_deliver: got pc=%h ins=%h expected pc=%h ins=%h", bus.if_pc, bus.if_instr, exp_pc, instr_of(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
         if (bus.redirect_valid) exp_pc = {bus.redirect_target[31:2], 2'b00};
         hold_prev = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
         req_prev = bus.imem_req && !bus.imem_gnt;
         sp = bus.if_pc; si = bus.if_instr; sa = bus.imem_addr;
         tick();
         if (req_prev) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== sa) begin errors++; $display("FAIL rnd_req_stable: got req=%b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, sa); end
         end
         if (hold_prev) begin
            checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== sp || bus.if_instr !== si) begin errors++; $display("FAIL rnd_hold_stable: got v=%b pc=%h ins=%h expected 1 %h %h", bus.if_valid, bus.if_pc, bus.if_instr, sp, si); end
         end
      end
      checks++; if (ndel < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected >= 100", ndel); end
      bus.redirect_valid = 0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.stall = 1; bus.redirect_valid = 0; bus.redirect_target = 0; bus.if_ready = 0;
      rand_mem = 0; gnt_delay = 0; rv_delay = 0;
      mem_reset();
      test_reset();
      test_sequential();
      test_hold_stable();
      test_redirect_wait();
      test_double_redirect();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
